// File: rtl/seg_mux_accumulator.sv
// Accumulating adder with a sticky overflow flag, shown on a scanned common-anode hex display.
// One digit is lit every REFRESH_DIV clocks; the outputs are registered, so they change one clock after the digit index or R.
module seg_mux_accumulator #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  op_valid,
  input  logic                  op_sel,
  output logic [DIGITS-1:0]     AN,
  output logic [6:0]            DISPLAY,
  output logic                  OVERFLOW
);

  localparam int W     = 4 * DIGITS;
  localparam int PC_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [W-1:0]     r;
  logic             ovf;
  logic [W:0]       sum;
  logic [PC_W-1:0]  pc;
  logic [IDX_W-1:0] idx;
  logic             pc_wrap;
  logic [3:0]       nib;
  logic             upper_zero;
  logic             blank;
  logic [DIGITS-1:0] an_next;
  logic [6:0]       seg_next;

  // Carry is the extra top bit of a W+1 bit add.
  always_comb begin
    sum = '0;
    if (op_sel) begin
      sum = {1'b0, r} + {1'b0, a};
    end else begin
      sum = {1'b0, a} + {1'b0, b};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r   <= '0;
      ovf <= 1'b0;
    end else if (op_valid) begin
      r <= sum[W-1:0];
      if (op_sel) begin
        ovf <= ovf | sum[W];
      end else begin
        ovf <= sum[W];
      end
    end
  end

  assign OVERFLOW = ovf;

  assign pc_wrap = (pc == PC_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else if (pc_wrap) begin
      pc <= '0;
    end else begin
      pc <= pc + PC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
    end else if (pc_wrap) begin
      if (idx == IDX_LAST) begin
        idx <= '0;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  // Nibble mux and leading-zero detect over all digits at or above idx.
  always_comb begin
    nib        = '0;
    upper_zero = 1'b1;
    an_next    = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib        = r[4*i +: 4];
        an_next[i] = 1'b0;
      end
      if ((IDX_W'(i) >= idx) && (r[4*i +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
  end

  assign blank = BLANK_LZ && (idx != '0) && upper_zero;

  always_comb begin
    seg_next = 7'h7F;
    case (nib)
      4'h0: seg_next = 7'h40;
      4'h1: seg_next = 7'h79;
      4'h2: seg_next = 7'h24;
      4'h3: seg_next = 7'h30;
      4'h4: seg_next = 7'h19;
      4'h5: seg_next = 7'h12;
      4'h6: seg_next = 7'h02;
      4'h7: seg_next = 7'h78;
      4'h8: seg_next = 7'h00;
      4'h9: seg_next = 7'h10;
      4'hA: seg_next = 7'h08;
      4'hB: seg_next = 7'h03;
      4'hC: seg_next = 7'h46;
      4'hD: seg_next = 7'h21;
      4'hE: seg_next = 7'h06;
      4'hF: seg_next = 7'h0E;
      default: seg_next = 7'h7F;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      AN      <= '1;
      DISPLAY <= 7'h7F;
    end else begin
      AN      <= an_next;
      DISPLAY <= blank ? 7'h7F : seg_next;
    end
  end

endmodule
